fir_output_decimator: RTL and testbench

Decimate-by-N output stage directly downstream of the 19-tap FIR filter. Takes the FIR's 16-bit output stream, keeps one sample in every `DECIM`, and buffers kept samples in a small first-word-fall-through FIFO. The FIFO gives a consumer with real backpressure on `m_axis_data_tready` a clean handshake, because the FIR itself ignores backpressure. Overflows are dropped, counted, and flagged, never stalled.

---
 rtl/fir_pkg.sv | 9 +
 rtl/fir_output_decimator_if.sv | 9 +
 rtl/sync_fifo_fwft.sv | 37 +++
 rtl/fir_output_decimator.sv | 54 +++++
 tb/tb_fir_output_decimator.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: sample types and widths shared by the FIR stage and its output decimator.
package fir_pkg;
    localparam int SAMPLE_W   = 16;
    localparam int DROP_CNT_W = 16;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/fir_output_decimator_if.sv
// fir_output_decimator_if: AXI-stream sample channel (valid/ready/data).
interface fir_output_decimator_if;
    import fir_pkg::*;
    logic    tvalid;
    logic    tready;
    sample_t tdata;
    modport master(output tvalid, output tdata, input tready);
    modport slave(input tvalid, input tdata, output tready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: register-array first-word-fall-through FIFO; occupancy counter resolves full/empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign level = cnt;
    // head is masked to zero when empty so the output bus idles at 0
    assign rdata = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/fir_output_decimator.sv
// fir_output_decimator: keeps one FIR sample in DECIM and buffers it for a backpressured consumer.
// The FIR cannot stall, so a full FIFO drops kept samples and counts them instead.
module fir_output_decimator
    import fir_pkg::*;
#(
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    fir_output_decimator_if.slave     s_axis_data,
    fir_output_decimator_if.master    m_axis_data,
    input  logic                      clear_overflow,
    output logic                      overflow,
    output logic [DROP_CNT_W-1:0]     drop_count,
    output logic [$clog2(DEPTH):0]    fill_level
);
    localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
    logic [PW-1:0] phase;
    logic          rdy, xfer, kept, push, pop, drop, full, empty;
    sample_t       head;
    assign s_axis_data.tready = rdy;
    assign xfer = s_axis_data.tvalid && rdy;
    assign kept = xfer && phase == '0;
    assign pop  = m_axis_data.tvalid && m_axis_data.tready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push = kept && (!full || pop);
    assign drop = kept && full && !pop;
    assign m_axis_data.tvalid = !empty;
    assign m_axis_data.tdata  = head;
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            rdy        <= 1'b0;
            phase      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            rdy <= 1'b1;
            if (xfer) phase <= phase == PW'(DECIM-1) ? '0 : phase + 1'b1;
            overflow   <= drop | (overflow & ~clear_overflow);
            drop_count <= clear_overflow ? '0 : drop ? sat_inc(drop_count) : drop_count;
        end
    sync_fifo_fwft #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (push),
        .wdata (s_axis_data.tdata),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fill_level)
    );
endmodule

// File: tb/tb_fir_output_decimator.sv
// tb_fir_output_decimator: DECIM=1 and DECIM=4 instances on one stimulus stream, checked against a queue model.
module tb_fir_output_decimator;
    import fir_pkg::*;
    logic aclk = 1'b0, aresetn = 1'b0, clr = 1'b0;
    always #5 aclk = ~aclk;
    fir_output_decimator_if s0(), s1(), m0(), m1();
    logic           ov [2];
    logic [15:0]    dc [2];
    logic [3:0]     fl [2];
    logic           tv [2], sr [2];
    sample_t        td [2];
    fir_output_decimator #(.DECIM(1), .DEPTH(8)) u1 (
        .aclk(aclk), .aresetn(aresetn), .s_axis_data(s0), .m_axis_data(m0),
        .clear_overflow(clr), .overflow(ov[0]), .drop_count(dc[0]), .fill_level(fl[0]));
    fir_output_decimator #(.DECIM(4), .DEPTH(8)) u4 (
        .aclk(aclk), .aresetn(aresetn), .s_axis_data(s1), .m_axis_data(m1),
        .clear_overflow(clr), .overflow(ov[1]), .drop_count(dc[1]), .fill_level(fl[1]));
    assign tv[0] = m0.tvalid;
    assign tv[1] = m1.tvalid;
    assign td[0] = m0.tdata;
    assign td[1] = m1.tdata;
    assign sr[0] = s0.tready;
    assign sr[1] = s1.tready;
    int total = 0, bad = 0;
    int dec [2] = '{1, 4};
    int ph [2], drops [2], prev [2];
    bit ovm [2], stall [2];
    bit rdy_m;
    int q [2][$];
    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic drive(input bit v, input int d, input bit rdy, input bit c);
        s0.tvalid = v;
        s1.tvalid = v;
        s0.tdata  = sample_t'(d);
        s1.tdata  = sample_t'(d);
        m0.tready = rdy;
        m1.tready = rdy;
        clr       = c;
    endtask
    task automatic rst_dut();
        @(negedge aclk);
        drive(0, 0, 0, 0);
        #2 aresetn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_s_tready", sr[i], 0);
            chk("rst_m_tvalid", tv[i], 0);
            chk("rst_m_tdata", td[i], 0);
            chk("rst_fill", fl[i], 0);
            chk("rst_overflow", ov[i], 0);
            chk("rst_drops", dc[i], 0);
            q[i].delete();
            ph[i] = 0;
            drops[i] = 0;
            ovm[i] = 0;
            stall[i] = 0;
        end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("rel_s_tready", sr[0], 0);
        rdy_m = 1'b1;
    endtask
    task automatic cyc(input bit v, input int d, input bit rdy, input bit c);
        @(negedge aclk);
        drive(v, d, rdy, c);
        #1;
        for (int i = 0; i < 2; i++) begin
            bit pop, kept, push;
            chk("s_tready", sr[i], rdy_m);
            chk("m_tvalid", tv[i], q[i].size() > 0);
            chk("fill_level", fl[i], q[i].size());
            chk("overflow", ov[i], ovm[i]);
            chk("drop_count", dc[i], drops[i]);
            if (stall[i]) chk("stall_tdata", td[i], prev[i]);
            pop = q[i].size() > 0 && rdy;
            if (pop) begin
                chk("m_tdata", td[i], q[i][0]);
                void'(q[i].pop_front());
            end
            stall[i] = tv[i] && !rdy;
            prev[i] = td[i];
            kept = v && rdy_m && ph[i] == 0;
            if (v && rdy_m) ph[i] = (ph[i] + 1) % dec[i];
            push = kept && q[i].size() < 8;
            if (push) q[i].push_back(d);
            if (c) drops[i] = 0;
            else if (kept && !push && drops[i] != 65535) drops[i]++;
            ovm[i] = (kept && !push) || (ovm[i] && !c);
        end
        rdy_m = aresetn;
    endtask
    initial begin
        drive(0, 0, 0, 0);
        rst_dut();
        cyc(1, 100, 1, 0);
        cyc(1, -200, 1, 0);
        cyc(1, 300, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        rst_dut();
        for (int i = 0; i < 12; i++) cyc(1, i, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        rst_dut();
        for (int i = 0; i < 16; i++) cyc(i % 2 == 0, 20 + i / 2, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        rst_dut();
        for (int i = 1; i <= 10; i++) cyc(1, i, 0, 0);
        @(posedge aclk);
        #1;
        chk("ovf_fill8", fl[0], 8);
        chk("ovf_flag", ov[0], 1);
        chk("ovf_drops2", dc[0], 2);
        chk("ovf_d4_fill3", fl[1], 3);
        repeat (5) cyc(0, 0, 0, 0);
        cyc(1, 77, 1, 0);
        @(posedge aclk);
        #1;
        chk("fullpop_fill8", fl[0], 8);
        chk("fullpop_drops2", dc[0], 2);
        repeat (12) cyc(0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) cyc(1, 40 + i, 0, 0);
        cyc(0, 0, 0, 1);
        @(posedge aclk);
        #1;
        chk("clr_ovf", ov[0], 0);
        chk("clr_drops", dc[0], 0);
        cyc(1, 99, 0, 1);
        @(posedge aclk);
        #1;
        chk("clrdrop_ovf", ov[0], 1);
        chk("clrdrop_drops", dc[0], 0);
        cyc(0, 0, 0, 0);
        repeat (10) cyc(0, 0, 1, 0);
        rst_dut();
        for (int i = 0; i < 5; i++) cyc(1, 60 + i, 0, 0);
        @(posedge aclk);
        #1;
        chk("pre_rst_fill5", fl[0], 5);
        rst_dut();
        cyc(1, 555, 1, 0);
        repeat (2) cyc(0, 0, 1, 0);
        for (int i = 0; i < 2; i++) chk("queue_drained", q[i].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
